// File: rtl/dmem_rmw_ctrl_if.sv
// Core-side request/response and SRAM-side port bundle for the data-memory controller.
// slave is the controller's view; master is the core + SRAM side.
interface dmem_rmw_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic [31:0]       req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              req_write_i;
  logic              req_read_i;
  logic [3:0]        req_sign_mask_i;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              misalign_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic              sram_re_o;
  logic              sram_we_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  modport slave (
    input  req_addr_i, req_wdata_i, req_write_i, req_read_i, req_sign_mask_i, sram_rdata_i,
    output rdata_o, stall_o, misalign_o, sram_addr_o, sram_re_o, sram_we_o, sram_wdata_o
  );

  modport master (
    output req_addr_i, req_wdata_i, req_write_i, req_read_i, req_sign_mask_i, sram_rdata_i,
    input  rdata_o, stall_o, misalign_o, sram_addr_o, sram_re_o, sram_we_o, sram_wdata_o
  );
endinterface

// File: rtl/dmem_rmw_ctrl.sv
// RV32I MEM-stage data controller for a word-only SRAM: sub-word stores via read-modify-write,
// loads aligned and sign/zero-extended, one stall cycle for every two-cycle access.
module dmem_rmw_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic            clk_i,
  input  logic            reset_i,
  dmem_rmw_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_MERGE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_off;
  logic              r_byte;
  logic              r_half;
  logic              r_sign;
  logic [15:0]       r_wdata;
  logic [31:0]       r_hold;

  logic              w_byte;
  logic              w_half;
  logic              w_word;
  logic              w_store;
  logic              w_load;
  logic              w_mis;
  logic              w_two;
  logic [ADDR_W-1:0] w_req_word;
  logic [31:0]       w_ld_data;
  logic              w_unused;

  function automatic logic [31:0] f_align_load(input logic [31:0] word, input logic [1:0] off,
                                               input logic is_byte, input logic is_half,
                                               input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    if (is_byte)      return {{24{sgn & b[7]}}, b};
    else if (is_half) return {{16{sgn & h[15]}}, h};
    else              return word;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] off,
                                          input logic is_byte, input logic is_half,
                                          input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (is_byte)                r[{off, 3'b000} +: 8] = wdata[7:0];
    else if (is_half && off[1]) r[31:16] = wdata;
    else if (is_half)           r[15:0]  = wdata;
    return r;
  endfunction

  // Request decode: write wins over read; a non-one-hot size behaves as a word.
  assign w_byte     = (bus.req_sign_mask_i[2:0] == 3'b001);
  assign w_half     = (bus.req_sign_mask_i[2:0] == 3'b010);
  assign w_word     = ~(w_byte | w_half);
  assign w_store    = bus.req_write_i;
  assign w_load     = bus.req_read_i & ~bus.req_write_i;
  assign w_mis      = (w_store | w_load) &
                      ((w_half & bus.req_addr_i[0]) | (w_word & (bus.req_addr_i[1:0] != 2'b00)));
  assign w_two      = ~w_mis & (w_load | (w_store & ~w_word));
  assign w_req_word = bus.req_addr_i[ADDR_W+1:2];
  assign w_ld_data  = f_align_load(bus.sram_rdata_i, r_off, r_byte, r_half, r_sign);
  assign w_unused   = ^{bus.req_addr_i[31:ADDR_W+2]};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_two) w_next = w_load ? S_LOAD : S_MERGE;
      S_LOAD:  w_next = S_IDLE;
      S_MERGE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Access context captured on the first cycle keeps the SRAM address stable for the second.
  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && w_two) begin
      r_addr  <= w_req_word;
      r_off   <= bus.req_addr_i[1:0];
      r_byte  <= w_byte;
      r_half  <= w_half;
      r_sign  <= bus.req_sign_mask_i[3];
      r_wdata <= bus.req_wdata_i[15:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)               r_hold <= 32'd0;
    else if (r_state == S_LOAD) r_hold <= w_ld_data;
  end

  always_comb begin
    bus.stall_o      = 1'b0;
    bus.sram_re_o    = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.misalign_o   = 1'b0;
    bus.sram_addr_o  = w_req_word;
    bus.sram_wdata_o = bus.req_wdata_i;
    bus.rdata_o      = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_mis) begin
          bus.misalign_o = 1'b1;
          bus.rdata_o    = 32'd0;
        end else if (w_store && w_word) begin
          bus.sram_we_o = 1'b1;
        end else if (w_two) begin
          bus.sram_re_o = 1'b1;
          bus.stall_o   = 1'b1;
        end
      end
      S_LOAD: begin
        bus.sram_addr_o = r_addr;
        bus.rdata_o     = w_ld_data;
      end
      S_MERGE: begin
        bus.sram_addr_o  = r_addr;
        bus.sram_we_o    = 1'b1;
        bus.sram_wdata_o = f_merge(bus.sram_rdata_i, r_off, r_byte, r_half, r_wdata);
      end
      default: ;
    endcase
    // Strobes held by the core must not reach the SRAM while reset is asserted.
    if (reset_i) begin
      bus.stall_o    = 1'b0;
      bus.sram_re_o  = 1'b0;
      bus.sram_we_o  = 1'b0;
      bus.misalign_o = 1'b0;
      bus.rdata_o    = 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Bench for dmem_rmw_ctrl: behavioural SRAM, load-result scoreboard queue and a word-level
// reference model for a randomized sub-word store/load phase.
module tb_dmem_rmw_ctrl;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] exp_q [$];
  logic [31:0] ref_w [0:7];

  dmem_rmw_ctrl_if #(.ADDR_W(AW)) bus ();
  dmem_rmw_ctrl #(.ADDR_W(AW)) dut (.clk_i(clk), .reset_i(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
    if (bus.sram_re_o) bus.sram_rdata_i <= mem[bus.sram_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [3:0] mk,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_write_i     = wr;
    bus.req_read_i      = rd;
    bus.req_sign_mask_i = mk;
    bus.req_addr_i      = a;
    bus.req_wdata_i     = wd;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b0100, 32'd0, 32'd0);
    #1;
  endtask

  function automatic logic [31:0] size_mask(input int sz);
    return (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input int off, input int sz,
                                            input logic [31:0] wd);
    logic [31:0] m;
    m = size_mask(sz) << (off * 8);
    return (old & ~m) | ((wd << (off * 8)) & m);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input int sz,
                                           input bit sgn);
    logic [31:0] v;
    v = (word >> (off * 8)) & size_mask(sz);
    if (sgn && sz < 4 && v[sz*8-1]) v = v | ~size_mask(sz);
    return v;
  endfunction

  // One complete access starting at the next falling edge; the request is held through stall.
  task automatic access(input logic wr, input logic rd, input logic [3:0] mk,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rexp);
    logic        word_sz, mis, ld;
    logic [31:0] waddr;
    word_sz = !(mk[2:0] == 3'b001 || mk[2:0] == 3'b010);
    mis     = (mk[2:0] == 3'b010 && a[0]) || (word_sz && a[1:0] != 2'b00);
    ld      = rd && !wr;
    waddr   = 32'(a[AW+1:2]);
    @(negedge clk);
    drive(wr, rd, mk, a, wd);
    #1;
    chk("misalign", 32'(bus.misalign_o), 32'(mis));
    if (mis) begin
      chk("mis_re", 32'(bus.sram_re_o), 32'd0);
      chk("mis_we", 32'(bus.sram_we_o), 32'd0);
      chk("mis_stall", 32'(bus.stall_o), 32'd0);
      chk("mis_rdata", bus.rdata_o, 32'd0);
    end else if (!ld && word_sz) begin
      chk("sw_we", 32'(bus.sram_we_o), 32'd1);
      chk("sw_re", 32'(bus.sram_re_o), 32'd0);
      chk("sw_stall", 32'(bus.stall_o), 32'd0);
      chk("sw_addr", 32'(bus.sram_addr_o), waddr);
      chk("sw_wdata", bus.sram_wdata_o, wd);
    end else begin
      chk("c1_re", 32'(bus.sram_re_o), 32'd1);
      chk("c1_we", 32'(bus.sram_we_o), 32'd0);
      chk("c1_stall", 32'(bus.stall_o), 32'd1);
      chk("c1_addr", 32'(bus.sram_addr_o), waddr);
      if (ld) exp_q.push_back(rexp);
      @(negedge clk);
      #1;
      chk("c2_stall", 32'(bus.stall_o), 32'd0);
      chk("c2_re", 32'(bus.sram_re_o), 32'd0);
      chk("c2_addr", 32'(bus.sram_addr_o), waddr);
      chk("c2_we", 32'(bus.sram_we_o), ld ? 32'd0 : 32'd1);
      if (ld) chk("rdata", bus.rdata_o, exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd, rexp;
    logic [3:0]  mk;
    int          w, off, sz, kind;
    bit          sgn;

    // Reset with a request already present: everything must stay quiet.
    rst = 1'b1;
    drive(1'b0, 1'b1, 4'b0100, 32'h10, 32'd0);
    #2;
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_re", 32'(bus.sram_re_o), 32'd0);
    chk("rst_we", 32'(bus.sram_we_o), 32'd0);
    chk("rst_mis", 32'(bus.misalign_o), 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'b0100, 32'd0, 32'd0);
    #1;
    chk("noreq_re", 32'(bus.sram_re_o), 32'd0);
    chk("noreq_we", 32'(bus.sram_we_o), 32'd0);
    chk("noreq_stall", 32'(bus.stall_o), 32'd0);

    // Word store then word load, result held afterwards.
    access(1, 0, 4'b0100, 32'h10, 32'hDEAD_BEEF, 0);
    access(0, 1, 4'b0100, 32'h10, 0, 32'hDEAD_BEEF);
    idle();
    chk("hold_lw", bus.rdata_o, 32'hDEAD_BEEF);

    // Byte read-modify-write, then signed and unsigned byte loads.
    access(1, 0, 4'b0100, 32'h10, 32'h1122_3344, 0);
    access(1, 0, 4'b0001, 32'h12, 32'h0000_00AA, 0);
    access(0, 1, 4'b1001, 32'h12, 0, 32'hFFFF_FFAA);
    access(0, 1, 4'b0001, 32'h12, 0, 32'h0000_00AA);
    idle();
    chk("mem_sb", mem[4], 32'h11AA_3344);

    // Half read-modify-write on a zero word, then signed half load.
    access(1, 0, 4'b0100, 32'h14, 32'h0, 0);
    access(1, 0, 4'b0010, 32'h16, 32'h0000_8001, 0);
    access(0, 1, 4'b1010, 32'h16, 0, 32'hFFFF_8001);
    idle();
    chk("mem_sh", mem[5], 32'h8001_0000);

    // Misaligned word load and half store.
    access(0, 1, 4'b0100, 32'h13, 0, 0);
    access(1, 0, 4'b0010, 32'h11, 32'h0000_BEEF, 0);
    idle();
    chk("mis_pulse_end", 32'(bus.misalign_o), 32'd0);
    chk("mem_mis", mem[4], 32'h11AA_3344);

    // Both strobes high is a store; then an aliased address wraps onto the same word.
    access(1, 1, 4'b0100, 32'h20, 32'h1234_5678, 0);
    idle();
    chk("mem_rw", mem[8], 32'h1234_5678);
    access(1, 0, 4'b0100, 32'h20 + (32'd1 << (AW + 2)), 32'h5, 0);
    idle();
    chk("mem_wrap", mem[8], 32'h5);

    // Non-one-hot size fields behave as word accesses.
    access(1, 0, 4'b0111, 32'h28, 32'h0BAD_F00D, 0);
    access(0, 1, 4'b1000, 32'h28, 0, 32'h0BAD_F00D);

    // Reset during the merge cycle of a byte store.
    access(1, 0, 4'b0100, 32'h24, 32'hCAFE_F00D, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'b0001, 32'h24, 32'h55);
    #1;
    chk("rmw_c1_stall", 32'(bus.stall_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmwrst_we", 32'(bus.sram_we_o), 32'd0);
    chk("rmwrst_re", 32'(bus.sram_re_o), 32'd0);
    chk("rmwrst_stall", 32'(bus.stall_o), 32'd0);
    chk("rmwrst_mis", 32'(bus.misalign_o), 32'd0);
    chk("rmwrst_rdata", bus.rdata_o, 32'd0);
    drive(1'b0, 1'b0, 4'b0100, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmwrst_mem", mem[9], 32'hCAFE_F00D);
    chk("rmwrst_hold", bus.rdata_o, 32'd0);
    access(0, 1, 4'b0001, 32'h24, 0, 32'h0000_000D);
    access(1, 0, 4'b0001, 32'h24, 32'h55, 0);
    access(0, 1, 4'b0100, 32'h24, 0, 32'hCAFE_F055);

    // Randomized back-to-back mix against the word-level reference model.
    for (int i = 0; i < 8; i++) begin
      ref_w[i] = $urandom;
      access(1, 0, 4'b0100, 32'h40 + 32'(i * 4), ref_w[i], 0);
    end
    for (int n = 0; n < 60; n++) begin
      w    = $urandom_range(0, 7);
      kind = $urandom_range(0, 3);
      sz   = 1 << $urandom_range(0, 2);
      off  = (sz == 1) ? $urandom_range(0, 3) : (sz == 2) ? 2 * $urandom_range(0, 1) : 0;
      sgn  = 1'($urandom_range(0, 1));
      mk   = {sgn, (sz == 4), (sz == 2), (sz == 1)};
      a    = 32'h40 + 32'(w * 4 + off);
      wd   = $urandom;
      if (kind == 0) begin
        rexp = ref_load(ref_w[w], off, sz, sgn);
        access(0, 1, mk, a, 0, rexp);
      end else begin
        ref_w[w] = ref_store(ref_w[w], off, sz, wd);
        access(1, 0, mk, a, wd, 0);
      end
    end
    idle();
    for (int i = 0; i < 8; i++) chk("rand_mem", mem[16+i], ref_w[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_rmw_ctrl.md
# dmem_rmw_ctrl

Data-memory controller sitting directly downstream of the RV32I core's MEM-stage data port: it consumes the core's address, write data, read/write strobes and 4-bit sign mask. It drives a word-wide single-port synchronous SRAM that has no byte enables. Sub-word stores are performed as read-modify-write, and loads are aligned and sign/zero-extended. A stall output freezes the core pipeline during two-cycle accesses.

## Interface
- `ADDR_W`, 10, SRAM word-address width (memory = 2^ADDR_W words).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `req_addr_i`  in  32  byte address from the core.
- `req_wdata_i`  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- `req_write_i`  in  1  store request.
- `req_read_i`  in  1  load request.
- `req_sign_mask_i`  in  4  access descriptor:
  - [3]=1 means sign-extend.
  - [2:0] is one-hot size: 001 byte, 010 half, 100 word.
- `rdata_o`  out  32  load result to the core.
- `stall_o`  out  1  core must hold its request and pipeline while high.
- `misalign_o`  out  1  one-cycle pulse on a misaligned request.
- `sram_addr_o`  out  ADDR_W  word address, `req_addr_i[ADDR_W+1:2]`; upper bits are ignored, so addresses wrap.
- `sram_re_o`  out  1  SRAM read enable.
- `sram_we_o`  out  1  SRAM write enable.
- `sram_wdata_o`  out  32  SRAM write word.
- `sram_rdata_i`  in  32  SRAM read word, valid the cycle after `sram_re_o`.

## Operation
- **States:** IDLE, LOAD, MERGE.
- **Request decode in IDLE:**
  - write priority: if `req_write_i` and `req_read_i` are both high, the request is treated as a store.
  - The read strobe is ignored in that case.
- **Misaligned requests:**
  - A request is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Response: `misalign_o`=1 for that cycle; no SRAM enable; no stall; `rdata_o`=0; stay in IDLE.
- **Size field:**
  - `req_sign_mask_i[2:0]` must be one-hot.
  - A non-one-hot value is treated as word.
- **Word store (IDLE):**
  - Combinationally assert `sram_we_o`=1 with `sram_wdata_o`=`req_wdata_i`.
  - `stall_o`=0; stay in IDLE.
- **Sub-word store:**
  - IDLE cycle: `sram_re_o`=1 and `stall_o`=1; latch byte offset, size and wdata; go to MERGE.
  - MERGE cycle:
    - Form the new word from `sram_rdata_i` with the target lane(s) replaced.
    - Byte: lane = addr[1:0], data = wdata[7:0].
    - Half: lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0].
    - `sram_we_o`=1, `stall_o`=0; next state IDLE.
  - `sram_addr_o` must be identical in both cycles: use the latched address.
- **Load:**
  - IDLE cycle: `sram_re_o`=1, `stall_o`=1; latch offset, size and sign; go to LOAD.
  - LOAD cycle:
    - `rdata_o` is combinationally the selected lane(s) of `sram_rdata_i`, shifted to bit 0.
    - Upper bits are filled with the lane MSB if sign=1, else zero.
    - `stall_o`=0; next state IDLE.
  - The result is also registered into a hold register on that edge.
  - In IDLE, `rdata_o` = hold register, except it is 0 on a misaligned cycle.
- **Request still present in the completion cycle:**
  - The core still presents the same request in the LOAD/MERGE cycle.
  - The controller ignores inputs in those states, so it never re-issues.
- **No request:** with no strobe in IDLE, all SRAM enables are 0 and `stall_o`=0.

## Timing
- **Reset values** (applied asynchronously, while reset is high):
  - state IDLE;
  - `stall_o`, `sram_re_o`, `sram_we_o`, `misalign_o` all 0;
  - hold register 0, so `rdata_o`=0.
- **Reset during LOAD/MERGE:** `sram_we_o` drops immediately and no partial write occurs.
- **Latency per access:**
  - Word store: 1 cycle.
  - Load: 2 cycles, with exactly 1 stall cycle.
  - Sub-word store: 2 cycles, with exactly 1 stall cycle.
- **Back-to-back:** a new request is accepted in the cycle right after LOAD/MERGE, with no bubble.
- **Output timing:**
  - `stall_o`, `sram_re_o` and `sram_we_o` are combinational from state and request.
  - No combinational path exists from `sram_rdata_i` to `stall_o`.

## Test plan
- **Word store then word load:**
  - Stimulus: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Required: store takes 1 cycle with no stall; load stalls 1 cycle; `rdata_o`=0xDEADBEEF in the LOAD cycle and held afterwards.
- **Byte RMW then signed/unsigned byte loads:**
  - Stimulus: memory[0x10]=0x11223344; SB 0xAA to 0x12; then LB 0x12 and LBU 0x12.
  - Required: word becomes 0x11AA3344; LB gives 0xFFFFFFAA; LBU gives 0x000000AA.
- **Half RMW then signed half load:**
  - Stimulus: SH 0x8001 to 0x16 on word 0; then LH 0x16.
  - Required: word becomes 0x80010000; LH gives 0xFFFF8001; each access stalls exactly 1 cycle.
- **Misaligned requests:**
  - Stimulus: LW 0x13, then SH 0x11.
  - Required: `misalign_o` pulses each time; no `sram_we_o`/`sram_re_o`; no stall; memory unchanged; `rdata_o`=0 during the LW cycle.
- **Simultaneous strobes and address wrap:**
  - Stimulus: read+write both high to 0x20; then SW 0x5 to (0x20 + 2^(ADDR_W+2)).
  - Required: the first request is performed as a store; the second overwrites word 0x20/4, confirming the wrap.
- **Reset mid-RMW:**
  - Stimulus: assert `reset_i` during the MERGE cycle of an SB.
  - Required: `sram_we_o` is 0 immediately; the memory word is unchanged; all outputs are at reset values; the next request after release behaves normally.
